// File: rtl/lcd_hd44780_rx.sv
// -----------------------------------------------------------------------------
// lcd_hd44780_rx
//
// Receiver-side model of an HD44780-compatible 2x16 character LCD. It watches
// the RS/EN/DATA bus produced by an LCD driver, takes one write on every falling
// edge of EN, and decodes it as a command (RS=0) or a character (RS=1). Only the
// two visible 16-character windows of DDRAM are stored; they are presented as
// 128-bit rows with column 0 in the top byte.
//
// Parameters
//   CLEAR_CYCLES  busy length after Clear Display / Return Home
//   CMD_CYCLES    busy length after any other command or a data write
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   RS           register select (0 = command, 1 = data)
//   EN           enable strobe, write taken on its falling edge
//   DATA[7:0]    bus value
//   row0/row1    visible lines, column 0 at [127:120], column 15 at [7:0]
//   addr[6:0]    DDRAM address counter
//   display_on   D bit of the last Display Control command
//   busy         model is executing; incoming writes are dropped
//   cmd_strobe   one-cycle pulse per accepted command
//   data_strobe  one-cycle pulse per accepted data write
//   overrun      sticky: a write arrived while busy
//   addr_err     sticky: Set DDRAM Address hit a hole in the address map
// -----------------------------------------------------------------------------
module lcd_hd44780_rx #(
  parameter int CLEAR_CYCLES = 82000,
  parameter int CMD_CYCLES   = 2000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         RS,
  input  logic         EN,
  input  logic [7:0]   DATA,
  output logic [127:0] row0,
  output logic [127:0] row1,
  output logic [6:0]   addr,
  output logic         display_on,
  output logic         busy,
  output logic         cmd_strobe,
  output logic         data_strobe,
  output logic         overrun,
  output logic         addr_err
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES);
  localparam logic [127:0]     BLANK_ROW  = {16{8'h20}};

  typedef enum logic [3:0] {
    CMD_NOP,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISPLAY,
    CMD_SHIFT,
    CMD_FUNC,
    CMD_CGRAM,
    CMD_DDRAM
  } cmd_e;

  // Input synchronizers plus one extra EN stage for edge detection.
  logic       en_s1_q, en_s2_q, en_d1_q;
  logic       rs_s1_q, rs_s2_q;
  logic [7:0] data_s1_q, data_s2_q;

  // Architectural state.
  logic [127:0]     row0_q, row0_d;
  logic [127:0]     row1_q, row1_d;
  logic [6:0]       addr_q, addr_d;
  logic             inc_q, inc_d;
  logic             disp_q, disp_d;
  logic             cgram_q, cgram_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             cmd_stb_q, cmd_stb_d;
  logic             data_stb_q, data_stb_d;
  logic             overrun_q, overrun_d;
  logic             addr_err_q, addr_err_d;

  logic fall;
  cmd_e cmd;

  // The DDRAM map has two 40-byte lines at 0x00 and 0x40; stepping wraps
  // between their ends rather than running through the holes.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      case (a)
        7'h27:   r = 7'h40;
        7'h67:   r = 7'h00;
        default: r = a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h00:   r = 7'h67;
        7'h40:   r = 7'h27;
        default: r = a - 7'd1;
      endcase
    end
    return r;
  endfunction

  assign fall = en_d1_q & ~en_s2_q;

  // Commands are classified by their highest set bit.
  always_comb begin
    cmd = CMD_NOP;
    casez (data_s2_q)
      8'b1???_????: cmd = CMD_DDRAM;
      8'b01??_????: cmd = CMD_CGRAM;
      8'b001?_????: cmd = CMD_FUNC;
      8'b0001_????: cmd = CMD_SHIFT;
      8'b0000_1???: cmd = CMD_DISPLAY;
      8'b0000_01??: cmd = CMD_ENTRY;
      8'b0000_001?: cmd = CMD_HOME;
      8'b0000_0001: cmd = CMD_CLEAR;
      default:      cmd = CMD_NOP;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so that no path
    // through the branches below leaves one unassigned and infers a latch.
    row0_d     = row0_q;
    row1_d     = row1_q;
    addr_d     = addr_q;
    inc_d      = inc_q;
    disp_d     = disp_q;
    cgram_d    = cgram_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    addr_err_d = addr_err_q;
    cmd_stb_d  = 1'b0;
    data_stb_d = 1'b0;
    busy_cnt_d = (busy_cnt_q != '0) ? busy_cnt_q - CNT_W'(1) : busy_cnt_q;

    if (fall) begin
      if (busy_cnt_q != '0) begin
        overrun_d = 1'b1;
      end else if (!rs_s2_q) begin
        cmd_stb_d  = 1'b1;
        busy_cnt_d = CMD_LOAD;
        case (cmd)
          CMD_NOP: busy_cnt_d = '0;
          CMD_CLEAR: begin
            row0_d     = BLANK_ROW;
            row1_d     = BLANK_ROW;
            addr_d     = 7'h00;
            inc_d      = 1'b1;
            cgram_d    = 1'b0;
            busy_cnt_d = CLEAR_LOAD;
          end
          CMD_HOME: begin
            addr_d     = 7'h00;
            cgram_d    = 1'b0;
            busy_cnt_d = CLEAR_LOAD;
          end
          CMD_ENTRY:   inc_d  = data_s2_q[1];
          CMD_DISPLAY: disp_d = data_s2_q[2];
          CMD_SHIFT: begin
            // Only cursor moves (S/C=0) touch the address counter.
            if (!data_s2_q[3]) addr_d = step_addr(addr_q, data_s2_q[2]);
          end
          CMD_FUNC:  ;
          CMD_CGRAM: cgram_d = 1'b1;
          CMD_DDRAM: begin
            addr_d  = data_s2_q[6:0];
            cgram_d = 1'b0;
            // Offsets 0x28..0x3F within either line do not exist.
            if (data_s2_q[5:0] >= 6'h28) begin
              valid_d    = 1'b0;
              addr_err_d = 1'b1;
            end else begin
              valid_d = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        data_stb_d = 1'b1;
        busy_cnt_d = CMD_LOAD;
        if (!cgram_q && valid_q) begin
          for (int c = 0; c < 16; c++) begin
            if (addr_q == 7'(c))        row0_d[8*(15-c) +: 8] = data_s2_q;
            if (addr_q == 7'(c + 'h40)) row1_d[8*(15-c) +: 8] = data_s2_q;
          end
          addr_d = step_addr(addr_q, inc_q);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_s1_q    <= 1'b0;
      en_s2_q    <= 1'b0;
      en_d1_q    <= 1'b0;
      rs_s1_q    <= 1'b0;
      rs_s2_q    <= 1'b0;
      data_s1_q  <= 8'h00;
      data_s2_q  <= 8'h00;
      // NOTE: the visible DDRAM window is plain flops, not a RAM macro, so it
      // can and must be reset to blanks along with the rest of the state.
      row0_q     <= BLANK_ROW;
      row1_q     <= BLANK_ROW;
      addr_q     <= 7'h00;
      inc_q      <= 1'b1;
      disp_q     <= 1'b0;
      cgram_q    <= 1'b0;
      valid_q    <= 1'b1;
      busy_cnt_q <= '0;
      cmd_stb_q  <= 1'b0;
      data_stb_q <= 1'b0;
      overrun_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      en_s1_q    <= EN;
      en_s2_q    <= en_s1_q;
      en_d1_q    <= en_s2_q;
      rs_s1_q    <= RS;
      rs_s2_q    <= rs_s1_q;
      data_s1_q  <= DATA;
      data_s2_q  <= data_s1_q;
      row0_q     <= row0_d;
      row1_q     <= row1_d;
      addr_q     <= addr_d;
      inc_q      <= inc_d;
      disp_q     <= disp_d;
      cgram_q    <= cgram_d;
      valid_q    <= valid_d;
      busy_cnt_q <= busy_cnt_d;
      cmd_stb_q  <= cmd_stb_d;
      data_stb_q <= data_stb_d;
      overrun_q  <= overrun_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign row0        = row0_q;
  assign row1        = row1_q;
  assign addr        = addr_q;
  assign display_on  = disp_q;
  assign busy        = (busy_cnt_q != '0);
  assign cmd_strobe  = cmd_stb_q;
  assign data_strobe = data_stb_q;
  assign overrun     = overrun_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// -----------------------------------------------------------------------------
// tb_lcd_hd44780_rx
//
// Directed bench for lcd_hd44780_rx with CLEAR_CYCLES=20, CMD_CYCLES=8. A table
// of bus writes with hand-computed address / display_on results is applied in
// groups, with row contents checked between groups; hand-written sequences
// cover busy length, overrun, addr_err, a full driver-style text load and
// reset during busy or during a pending EN edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_hd44780_rx;

  localparam logic [127:0] SP = {16{8'h20}};

  logic         clk = 1'b0;
  logic         reset;
  logic         RS, EN;
  logic [7:0]   DATA;
  logic [127:0] row0, row1;
  logic [6:0]   addr;
  logic         display_on, busy, cmd_strobe, data_strobe, overrun, addr_err;

  lcd_hd44780_rx #(.CLEAR_CYCLES(20), .CMD_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .RS          (RS),
    .EN          (EN),
    .DATA        (DATA),
    .row0        (row0),
    .row1        (row1),
    .addr        (addr),
    .display_on  (display_on),
    .busy        (busy),
    .cmd_strobe  (cmd_strobe),
    .data_strobe (data_strobe),
    .overrun     (overrun),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cmd    = 0;
  int n_data   = 0;

  always @(posedge clk) begin
    if (cmd_strobe)  n_cmd++;
    if (data_strobe) n_data++;
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [6:0] exp_addr;
    logic       exp_disp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rs, input logic [7:0] d, input logic [6:0] a, input logic disp);
    vec_t v;
    v.rs = rs; v.data = d; v.exp_addr = a; v.exp_disp = disp;
    vecs.push_back(v);
  endtask

  // One bus write; returns three negedges after the EN fall, which is just
  // after the update edge.
  task automatic pulse(input logic rs, input logic [7:0] d);
    @(negedge clk);
    RS = rs; DATA = d;
    repeat (2) @(negedge clk);
    EN = 1'b1;
    repeat (3) @(negedge clk);
    EN = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    pulse(rs, d);
    @(negedge clk);
    wait_idle();
  endtask

  task automatic measure_busy(input string name, input int exp);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, n, exp);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      int c0 = n_cmd;
      int d0 = n_data;
      send(vecs[i].rs, vecs[i].data);
      check($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_disp", i), display_on, vecs[i].exp_disp);
      check($sformatf("vec%0d_strobes", i), {n_cmd - c0, n_data - d0},
            {32'(vecs[i].rs ? 0 : 1), 32'(vecs[i].rs ? 1 : 0)});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b1, b2, b3, b4, b5;
    int c0, d0;
    logic [127:0] txt0, txt1;

    // Hello group
    add(0, 8'h01, 7'h00, 0);
    add(0, 8'h0C, 7'h00, 1);
    add(1, "H", 7'h01, 1);
    add(1, "E", 7'h02, 1);
    add(1, "L", 7'h03, 1);
    add(1, "L", 7'h04, 1);
    add(1, "O", 7'h05, 1);
    b1 = vecs.size();
    // Second line
    add(0, 8'hC0, 7'h40, 1);
    add(1, "A", 7'h41, 1);
    add(1, "B", 7'h42, 1);
    b2 = vecs.size();
    // Decrement mode: 0x00 -> 0x67 and 0x40 -> 0x27
    add(0, 8'h04, 7'h42, 1);
    add(0, 8'h80, 7'h00, 1);
    add(1, "Z", 7'h67, 1);
    add(0, 8'hC0, 7'h40, 1);
    add(1, "W", 7'h27, 1);
    b3 = vecs.size();
    // Increment across 0x27 -> 0x40
    add(0, 8'h06, 7'h27, 1);
    add(0, 8'hA7, 7'h27, 1);
    add(1, "X", 7'h40, 1);
    add(1, "Y", 7'h41, 1);
    b4 = vecs.size();
    // 0x67 -> 0x00 wrap, shifts, misc commands, CGRAM skip
    add(0, 8'hE7, 7'h67, 1);
    add(1, "-", 7'h00, 1);
    add(0, 8'h14, 7'h01, 1);
    add(0, 8'h10, 7'h00, 1);
    add(0, 8'h18, 7'h00, 1);
    add(0, 8'h38, 7'h00, 1);
    add(0, 8'h00, 7'h00, 1);
    add(0, 8'h08, 7'h00, 0);
    add(0, 8'h0C, 7'h00, 1);
    add(0, 8'hC5, 7'h45, 1);
    add(0, 8'h02, 7'h00, 1);
    add(0, 8'h40, 7'h00, 1);
    add(1, "Q", 7'h00, 1);
    add(0, 8'h80, 7'h00, 1);
    b5 = vecs.size();

    reset = 1'b1; RS = 1'b0; EN = 1'b0; DATA = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_row0", row0, SP);
    check("rst_row1", row1, SP);
    check("rst_addr", addr, 7'h00);
    check("rst_flags", {display_on, busy, cmd_strobe, data_strobe, overrun, addr_err}, 6'b0);

    run_vecs(0, b1);
    check("hello_row0", row0, {"HELLO", {11{8'h20}}});
    check("hello_strobes", n_cmd + n_data, 7);

    run_vecs(b1, b2);
    check("ab_row1", row1, {"AB", {14{8'h20}}});

    run_vecs(b2, b3);
    check("dec_row0", row0, {"ZELLO", {11{8'h20}}});
    check("dec_row1", row1, {"WB", {14{8'h20}}});

    run_vecs(b3, b4);
    check("inc_row0", row0, {"ZELLO", {11{8'h20}}});
    check("inc_row1", row1, {"YB", {14{8'h20}}});

    run_vecs(b4, b5);
    check("misc_row0", row0, {"ZELLO", {11{8'h20}}});
    check("misc_row1", row1, {"YB", {14{8'h20}}});
    check("misc_sticky", {overrun, addr_err}, 2'b00);

    // Busy length after an ordinary command.
    pulse(0, 8'h38);
    measure_busy("busy_len_cmd", 8);
    wait_idle();

    // Write during busy is dropped and sets overrun; a retry is accepted.
    send(0, 8'h80);
    c0 = n_cmd; d0 = n_data;
    pulse(1, "M");
    check("ovr_busy_up", busy, 1'b1);
    DATA = "N"; EN = 1'b1;
    repeat (3) @(negedge clk);
    EN = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle();
    check("ovr_flag", overrun, 1'b1);
    check("ovr_addr", addr, 7'h01);
    check("ovr_row0", row0, {"MELLO", {11{8'h20}}});
    check("ovr_strobes", {n_cmd - c0, n_data - d0}, {32'd0, 32'd1});
    send(1, "N");
    check("retry_addr", addr, 7'h02);
    check("retry_row0", row0, {"MNLLO", {11{8'h20}}});
    check("retry_ovr_sticky", overrun, 1'b1);

    // Invalid DDRAM address: data is swallowed but still strobes.
    send(0, 8'hB0);
    check("aerr_flag", addr_err, 1'b1);
    check("aerr_addr", addr, 7'h30);
    d0 = n_data;
    send(1, 8'h41);
    check("aerr_data_addr", addr, 7'h30);
    check("aerr_data_strobe", n_data - d0, 1);
    check("aerr_row0", row0, {"MNLLO", {11{8'h20}}});
    check("aerr_row1", row1, {"YB", {14{8'h20}}});

    // Driver-style init and text load; Clear busy length checked on the way.
    send(0, 8'h38);
    send(0, 8'h0C);
    pulse(0, 8'h01);
    measure_busy("busy_len_clear", 20);
    wait_idle();
    check("clear_rows", {row0, row1}, {SP, SP});
    send(0, 8'h06);
    txt0 = "Hello, World!   ";
    txt1 = "HD44780 2x16 LCD";
    send(0, 8'h80);
    for (int i = 0; i < 16; i++) send(1, txt0[8*(15-i) +: 8]);
    send(0, 8'hC0);
    for (int i = 0; i < 16; i++) send(1, txt1[8*(15-i) +: 8]);
    check("drv_row0", row0, txt0);
    check("drv_row1", row1, txt1);
    check("drv_addr", addr, 7'h50);

    // Reset while busy.
    pulse(0, 8'h01);
    check("rst_busy_pre", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rstbusy_busy", busy, 1'b0);
    check("rstbusy_rows", {row0, row1}, {SP, SP});
    check("rstbusy_addr", addr, 7'h00);
    check("rstbusy_sticky", {overrun, addr_err, display_on}, 3'b000);
    reset = 1'b0;

    // Reset with an EN fall in the synchronizer: the edge is discarded.
    @(negedge clk);
    RS = 1'b1; DATA = "Q";
    repeat (2) @(negedge clk);
    EN = 1'b1;
    repeat (3) @(negedge clk);
    c0 = n_cmd; d0 = n_data;
    EN = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("pend_strobes", {n_cmd - c0, n_data - d0}, {32'd0, 32'd0});
    check("pend_state", {row0, addr, busy}, {SP, 7'h00, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_rx.md
# lcd_hd44780_rx

Synthesizable receiver-side model of an HD44780-compatible 2x16 character LCD. It sits on the RS/EN/DATA bus that the LCD display driver produces and decodes each write into commands or characters. It maintains a DDRAM image and exposes the two visible rows as 128-bit vectors in the same packing the row generators use. It serves as a self-checking bench partner for the driver and as a loopback monitor on hardware.

## Interface
Parameters:
- CLEAR_CYCLES, 82000: busy duration in clk cycles after Clear Display or Return Home.
- CMD_CYCLES, 2000: busy duration in clk cycles after any other command or data write.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- RS  in  1  register select: 0 = command, 1 = data.
- EN  in  1  enable strobe; a write is taken on its falling edge.
- DATA  in  8  bus value.
- row0  out  128  visible line 0; column 0 at [127:120], column 15 at [7:0].
- row1  out  128  visible line 1, same packing.
- addr  out  7  DDRAM address counter.
- display_on  out  1  D bit of the last Display Control command.
- busy  out  1  model is executing; writes are not accepted.
- cmd_strobe  out  1  one-cycle pulse per accepted command.
- data_strobe  out  1  one-cycle pulse per accepted data write.
- overrun  out  1  sticky; a write arrived while busy.
- addr_err  out  1  sticky; Set DDRAM Address targeted an invalid address.

## Operation
- Reset values: all 32 row bytes 8'h20, addr 0, I/D=1, display_on 0, busy 0, both strobes 0, overrun 0, addr_err 0, CGRAM mode off, address-valid 1.
- EN, RS and DATA each pass through a 2-flop synchronizer. A falling edge is detected when the registered EN is high and the synchronized EN is low.
- A write detected while busy=1 is dropped and sets overrun. No other state changes.
- Commands (RS=0), decoded by the highest set bit:
  - 8'h00: no-op. Pulses cmd_strobe. busy is not set.
  - Clear (8'h01): all row bytes 8'h20, addr 0, I/D=1, CGRAM mode off. busy for CLEAR_CYCLES.
  - Return Home (8'h02/03): addr 0, CGRAM mode off. busy for CLEAR_CYCLES.
  - Entry Mode (0000_01 I/D S): latch I/D. S is ignored.
  - Display Control (0000_1DCB): display_on = D. C and B are ignored.
  - Shift (0001 S/C R/L xx): when S/C=0, step addr right (R/L=1) or left. When S/C=1, no effect.
  - Function Set (001x_xxxx): accepted, no effect.
  - Set CGRAM Address (01xx_xxxx): enter CGRAM mode.
  - Set DDRAM Address (1aaa_aaaa): addr = a, CGRAM mode off. If a is in 0x28–0x3F or 0x68–0x7F, set addr_err and address-valid=0; otherwise address-valid=1.
  - Every command except 8'h00 sets busy for CMD_CYCLES unless stated otherwise.
- Data (RS=1):
  - Skipped (no write, no address step) when CGRAM mode is on or address-valid=0. Still pulses data_strobe and sets busy.
  - Otherwise, write DATA to DDRAM[addr]. Addresses 0x00–0x0F land in row0 and 0x40–0x4F in row1. Addresses 0x10–0x27 and 0x50–0x67 are stored nowhere visible.
  - Then step addr per I/D.
- Address stepping:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - All other values change by ±1.

## Timing
- Let k be the first clk edge that samples EN low after it was high.
- All updates (rows, addr, flags, strobes, busy) take effect at edge k+2.
- Strobes are high for exactly the one cycle after k+2.
- RS and DATA must be stable from 2 clk before the EN fall until 3 clk after it. EN high and EN low must each last at least 3 clk.
- busy rises at edge k+2 and stays high for exactly N cycles, where N is CLEAR_CYCLES or CMD_CYCLES.
- A falling edge detected in the cycle busy first reads 0 is accepted.
- reset mid-operation (during busy or a pending edge) returns everything to reset values immediately. A pending edge is discarded.
- overrun and addr_err clear only on reset.

## Test plan
Benches set CLEAR_CYCLES=20 and CMD_CYCLES=8.
- After reset, send Clear, then Display Control 8'h0C, then "HELLO" as data. Required: row0[127:88] = "HELLO", rest of row0 is 8'h20, display_on=1, addr=5, 7 strobes total.
- Send Set DDRAM 8'hC0, then "AB". Required: row1[127:112]="AB", addr=0x42. With I/D=0 from DDRAM 8'h80, one data write gives addr=0x67.
- Set DDRAM 8'hA7, then two data writes. Required: addr 0x27→0x40→0x41, row1[127:120] = second character, row0 unchanged.
- Write during busy: a data write 4 cycles after the prior accept. Required: overrun=1, row and addr unchanged. A retry after busy falls is accepted.
- Set DDRAM 8'hB0, then data 8'h41. Required: addr_err=1, rows unchanged, addr stays 0x30, data_strobe pulses.
- Drive the full top-level driver output for its fixed text. Required: row0/row1 equal the generator's row0/row1 once the driver's sequence completes. Then assert reset mid-busy. Required: busy=0, rows all 8'h20 on the next cycle.
